// File: rtl/kdf_pkg.sv
// kdf_pkg: shared types and frame layout for the KDF parameter loader and
// the KDF testbenches.
//   kdf_ld_state_t : loader FSM states
//   FRAME_BYTES    : bytes per parameter frame
//   *_MSB          : top bit of each field inside the 128-bit assembled frame
//                    {password[31:0], salt[63:0], count[31:0]}
package kdf_pkg;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    ERR  = 3'd1,
    ARM  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } kdf_ld_state_t;

  localparam int FRAME_BYTES = 16;
  localparam int PW_MSB      = 127;
  localparam int SALT_MSB    = 95;
  localparam int COUNT_MSB   = 31;

endpackage

// File: rtl/kdf_param_loader.sv
// kdf_param_loader: front-end of the key-derivation stage.
// Assembles a 16-byte MSB-first frame {password, salt, count}, validates it,
// holds the KDF in reset while parameters settle, runs it, and returns the
// derived key over a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   s_valid/s_ready/s_data/s_last  byte stream in
//   kdf_rst                    active-high reset to the KDF (high = idle)
//   kdf_password/salt/count    parameters to the KDF, stable from ARM onward
//   kdf_end, kdf_key           KDF completion and result
//   key_valid/key_ready/key_data   derived key out
//   busy                       high outside LOAD
//   err                        one-cycle pulse on a rejected frame
module kdf_param_loader
  import kdf_pkg::*;
#(
  parameter logic [31:0] MAX_COUNT  = 32'h0000_FFFF,
  parameter int          ARM_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  output logic         kdf_rst,
  output logic [31:0]  kdf_password,
  output logic [63:0]  kdf_salt,
  output logic [31:0]  kdf_count,
  input  logic         kdf_end,
  input  logic [127:0] kdf_key,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_data,
  output logic         busy,
  output logic         err
);

  localparam int ACW = $clog2(ARM_CYCLES + 1);

  kdf_ld_state_t state, state_nxt;

  // Only the first 15 bytes need storage: the 16th is still on s_data when
  // the frame is judged, so frame_shift is the full 128-bit assembled frame.
  logic [119:0]   frame_q;
  logic [127:0]   frame_shift;
  logic [3:0]     byte_cnt;
  logic [ACW-1:0] arm_cnt;
  logic           last_seen_q;  // offending byte in LOAD already carried s_last
  logic           run_first_q;  // first RUN cycle: KDF not yet out of reset
  logic           xfer;
  logic           last_byte;
  logic           cnt_ok;
  logic [31:0]    cnt_field;

  assign xfer        = s_valid & s_ready;
  assign frame_shift = {frame_q, s_data};
  assign cnt_field   = frame_shift[COUNT_MSB:0];
  assign cnt_ok      = (cnt_field != 32'd0) && (cnt_field <= MAX_COUNT);
  assign last_byte   = (byte_cnt == 4'(FRAME_BYTES - 1));

  // Outputs are pure decodes of the state register, so async reset forces
  // kdf_rst high immediately.
  assign s_ready = (state == LOAD) || (state == ERR && !last_seen_q);
  assign kdf_rst = (state != RUN);
  assign busy    = (state != LOAD);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (xfer) begin
          if (s_last)         state_nxt = (last_byte && cnt_ok) ? ARM : ERR;
          else if (last_byte) state_nxt = ERR;
        end
      end
      ERR:  if (last_seen_q || (xfer && s_last)) state_nxt = LOAD;
      ARM:  if (arm_cnt == ACW'(1))                state_nxt = RUN;
      RUN:  if (!run_first_q && kdf_end)           state_nxt = DONE;
      DONE: if (key_valid && key_ready)            state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      frame_q      <= '0;
      byte_cnt     <= '0;
      arm_cnt      <= '0;
      last_seen_q  <= 1'b0;
      run_first_q  <= 1'b0;
      kdf_password <= '0;
      kdf_salt     <= '0;
      kdf_count    <= '0;
      key_valid    <= 1'b0;
      key_data     <= '0;
      err          <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state_nxt == ERR) && (state != ERR);
      case (state)
        LOAD: begin
          if (xfer) begin
            frame_q  <= frame_shift[119:0];
            byte_cnt <= byte_cnt + 4'd1;
          end
          if (state_nxt == ARM) begin
            kdf_password <= frame_shift[PW_MSB -: 32];
            kdf_salt     <= frame_shift[SALT_MSB -: 64];
            kdf_count    <= frame_shift[COUNT_MSB -: 32];
            arm_cnt      <= ACW'(ARM_CYCLES);
          end
          if (state_nxt == ERR) last_seen_q <= s_last;
        end
        ERR: begin
          if (state_nxt == LOAD) begin
            frame_q     <= '0;
            byte_cnt    <= '0;
            last_seen_q <= 1'b0;
          end
        end
        ARM: begin
          arm_cnt     <= arm_cnt - ACW'(1);
          run_first_q <= 1'b1;
        end
        RUN: begin
          run_first_q <= 1'b0;
          if (state_nxt == DONE) begin
            key_data  <= kdf_key;
            key_valid <= 1'b1;
          end
        end
        DONE: begin
          if (state_nxt == LOAD) begin
            key_valid <= 1'b0;
            byte_cnt  <= '0;
            frame_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kdf_param_loader.sv
// Testbench for kdf_param_loader with a small KDF stub and a key scoreboard.
module tb_kdf_param_loader;
  import kdf_pkg::*;

  localparam logic [31:0] MAX_COUNT  = 32'h0000_FFFF;
  localparam int          ARM_CYCLES = 2;

  logic         clk, rst_n;
  logic         s_valid, s_ready, s_last;
  logic [7:0]   s_data;
  logic         kdf_rst, kdf_end;
  logic [31:0]  kdf_password, kdf_count;
  logic [63:0]  kdf_salt;
  logic [127:0] kdf_key, key_data;
  logic         key_valid, key_ready, busy, err;

  kdf_param_loader #(.MAX_COUNT(MAX_COUNT), .ARM_CYCLES(ARM_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .kdf_rst(kdf_rst), .kdf_password(kdf_password), .kdf_salt(kdf_salt),
    .kdf_count(kdf_count), .kdf_end(kdf_end), .kdf_key(kdf_key),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference key function: 'count' rounds of rotate-and-mix.
  function automatic logic [127:0] kdf_model(input logic [31:0] pw,
                                             input logic [63:0] salt,
                                             input logic [31:0] cnt);
    logic [127:0] k;
    k = {pw, salt, cnt};
    for (int unsigned i = 0; i < cnt; i++)
      k = {k[126:0], k[127]} ^ {96'h0, pw} ^ 128'(i);
    return k;
  endfunction

  // KDF stub: finishes 3 cycles after leaving reset. It also raises a bogus
  // end with an inverted key in its very first cycle out of reset, which the
  // loader must ignore.
  logic [7:0]   stub_cnt;
  logic [127:0] stub_key;
  always @(posedge clk or negedge rst_n)
    if (!rst_n)               stub_cnt <= 8'd0;
    else if (kdf_rst)         stub_cnt <= 8'd0;
    else if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
  always @* stub_key = kdf_model(kdf_password, kdf_salt, kdf_count);
  assign kdf_end = !kdf_rst && (stub_cnt == 8'd0 || stub_cnt >= 8'd3);
  assign kdf_key = (stub_cnt == 8'd0) ? ~stub_key : stub_key;

  int checks = 0, failures = 0;
  int err_seen = 0, run_seen = 0;
  logic [127:0] exp_q[$];

  always @(negedge clk) begin
    if (err) err_seen++;
    if (!kdf_rst) run_seen++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    @(negedge clk);
    s_valid = 1'b1; s_data = b; s_last = last;
    n = 0;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) chk("byte_accept_timeout", 128'd0, 128'd1);
    @(posedge clk);
  endtask

  // Sends bytes first..nbytes-1 of the frame (bytes past 15 are filler),
  // s_last on byte last_at, then idles the stream at the next falling edge.
  task automatic send_frame(input logic [31:0] pw, input logic [63:0] salt,
                            input logic [31:0] cnt, input int first,
                            input int last_at, input int nbytes);
    logic [127:0] f;
    f = {pw, salt, cnt};
    for (int i = first; i < nbytes; i++)
      send_byte((i < 16) ? f[127-8*i -: 8] : 8'hA5, i == last_at);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Called at the first falling edge after the last byte: counts ARM cycles.
  task automatic check_arm(input string tag);
    int n;
    n = 0;
    while (kdf_rst && n < 50) begin n++; @(negedge clk); end
    chk({tag, "_arm_cycles"}, 128'(n), 128'(ARM_CYCLES));
  endtask

  task automatic get_key(input string tag);
    int n;
    logic [127:0] obs;
    n = 0;
    while (!key_valid && n < 200) begin @(negedge clk); n++; end
    if (!key_valid) begin chk({tag, "_key_timeout"}, 128'd0, 128'd1); return; end
    key_ready = 1'b1;
    obs = key_data;
    @(posedge clk);
    @(negedge clk);
    key_ready = 1'b0;
    chk({tag, "_key_valid_drop"}, 128'(key_valid), 128'd0);
    if (exp_q.size() == 0) chk({tag, "_scoreboard_empty"}, 128'd1, 128'd0);
    else chk({tag, "_key"}, obs, exp_q.pop_front());
  endtask

  task automatic good_frame(input string tag, input logic [31:0] pw,
                            input logic [63:0] salt, input logic [31:0] cnt);
    exp_q.push_back(kdf_model(pw, salt, cnt));
    send_frame(pw, salt, cnt, 0, 15, 16);
    chk({tag, "_count"}, 128'(kdf_count), 128'(cnt));
    chk({tag, "_pw_salt"}, {32'h0, kdf_password, kdf_salt}, {32'h0, pw, salt});
    check_arm(tag);
    get_key(tag);
  endtask

  task automatic bad_frame(input string tag, input logic [31:0] cnt,
                           input int last_at, input int nbytes);
    int e0, r0;
    e0 = err_seen; r0 = run_seen;
    send_frame(32'h1234_5678, 64'h0102_0304_0506_0708, cnt, 0, last_at, nbytes);
    repeat (3) @(negedge clk);
    chk({tag, "_err_pulses"}, 128'(err_seen - e0), 128'd1);
    chk({tag, "_no_run"}, 128'(run_seen - r0), 128'd0);
    chk({tag, "_idle"}, {126'd0, busy, kdf_rst}, 128'b01);
  endtask

  initial begin
    logic [127:0] held;
    logic         stable;
    logic [127:0] fb;
    int n;

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; key_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {122'd0, s_ready, kdf_rst, busy, key_valid, err, 1'b0}, {122'd0, 6'b110000});
    chk("reset_key", key_data, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: nominal frame
    good_frame("t1", 32'hDEAD_BEEF, 64'h0011_2233_4455_6677, 32'd3);

    // 2: short frame, then a good one
    bad_frame("t2", 32'd3, 9, 10);
    good_frame("t2_next", 32'hCAFE_F00D, 64'h8899_AABB_CCDD_EEFF, 32'd7);

    // 3: long frame, 3 extra bytes dropped
    bad_frame("t3", 32'd3, 18, 19);
    good_frame("t3_next", 32'h0BAD_CAFE, 64'h1122_3344_5566_7788, 32'd1);

    // 4: iteration count bounds
    bad_frame("t4_zero", 32'd0, 15, 16);
    bad_frame("t4_over", MAX_COUNT + 32'd1, 15, 16);
    good_frame("t4_max", 32'hFFFF_0000, 64'hFEDC_BA98_7654_3210, MAX_COUNT);

    // 5: key held under back-pressure while the next frame's first byte waits
    exp_q.push_back(kdf_model(32'h5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0, 32'd2));
    send_frame(32'h5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0, 32'd2, 0, 15, 16);
    n = 0;
    while (!key_valid && n < 200) begin @(negedge clk); n++; end
    chk("t5_key_valid", 128'(key_valid), 128'd1);
    fb = {32'h7777_8888, 64'h99AA_BBCC_DDEE_FF00, 32'd4};
    s_valid = 1'b1; s_data = fb[127:120]; s_last = 1'b0;
    held = key_data; stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (key_data !== held || s_ready !== 1'b0 || key_valid !== 1'b1) stable = 1'b0;
    end
    chk("t5_hold_stable", 128'(stable), 128'd1);
    key_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_ready = 1'b0;
    chk("t5_key", held, exp_q.pop_front());
    exp_q.push_back(kdf_model(32'h7777_8888, 64'h99AA_BBCC_DDEE_FF00, 32'd4));
    send_frame(32'h7777_8888, 64'h99AA_BBCC_DDEE_FF00, 32'd4, 1, 15, 16);
    check_arm("t5_next");
    get_key("t5_next");

    // 6: async reset in RUN, then recovery
    send_frame(32'h1357_9BDF, 64'h2468_ACE0_1357_9BDF, 32'd5, 0, 15, 16);
    n = 0;
    while (kdf_rst && n < 50) begin @(negedge clk); n++; end
    chk("t6_in_run", 128'(kdf_rst), 128'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", {125'd0, kdf_rst, key_valid, busy}, 128'b100);
    chk("t6_params_zero", {kdf_password, kdf_salt, kdf_count}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    good_frame("t6_next", 32'h2222_3333, 64'h4444_5555_6666_7777, 32'd6);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
